ll_op_arbiter: RTL

- Round-robin arbiter and sequencer that shares one linked-list engine (push-front, push-back, delete-by-value, traverse) among NUM_REQ requesters.
- Accepts one op at a time, drives the engine over a valid/ready handshake, waits for the engine's done pulse, and returns a status pulse to the issuing requester only.
- Sits between the switch/command front-ends and the linked-list datapath.

---
 rtl/ll_op_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ll_op_arbiter.sv
// ll_op_arbiter: round-robin arbiter/sequencer that shares one linked-list
// engine among NUM_REQ requesters. One op is in flight at a time; the status
// pulse goes back only to the requester that issued it.
// Optional build macro: LL_STRICT_PRIO_EN selects fixed priority, where the
// lowest index wins, in place of round-robin.
module ll_op_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [3*NUM_REQ-1:0]      req_op,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [1:0]                rsp_status,
   output logic                      eng_valid,
   output logic [2:0]                eng_op,
   output logic [DATA_W-1:0]         eng_data,
   input  logic                      eng_ready,
   input  logic                      eng_done,
   input  logic [1:0]                eng_status,
   output logic                      busy,
   output logic [ID_W-1:0]           grant_id
);

   // The watchdog only needs to reach TIMEOUT-1.
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] ST_OK_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [2:0]          op_q, op_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [1:0]          rsp_status_q, rsp_status_d;

`ifndef LL_STRICT_PRIO_EN
   logic [ID_W-1:0]     last_grant_q, last_grant_d;
`endif

   // Arbitration result for the current cycle.
   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic [2:0]          win_op;
   logic [DATA_W-1:0]   win_data;
   int unsigned         arb_pos;
   int unsigned         arb_idx;

   // Search order: walk the candidate list from its far end back to its
   // head so the last match written is the first in priority order.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_op    = '0;
      win_data  = '0;
      arb_pos   = 0;
      arb_idx   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         arb_pos = NUM_REQ - 1 - k;
`ifdef LL_STRICT_PRIO_EN
         arb_idx = arb_pos;
`else
         arb_idx = (32'(last_grant_q) + 1 + arb_pos) % NUM_REQ;
`endif
         if (req_valid[arb_idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(arb_idx);
            win_op    = req_op[3*arb_idx +: 3];
            win_data  = req_data[DATA_W*arb_idx +: DATA_W];
         end
      end
   end

   // Ready is offered only in IDLE, and only to the winner.
   always_comb begin
      req_ready = '0;
      if ((state_q == ST_IDLE) && win_found) begin
         req_ready[win_id] = 1'b1;
      end
   end

   // Next-state, capture and response logic.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      op_d         = op_q;
      data_d       = data_q;
      wd_d         = wd_q;
      rsp_valid_d  = '0;
      rsp_status_d = rsp_status_q;
`ifndef LL_STRICT_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_id_d = win_id;
               op_d       = win_op;
               data_d     = win_data;
`ifndef LL_STRICT_PRIO_EN
               last_grant_d = win_id;
`endif
               if (win_op[2]) begin
                  state_d = ST_ISSUE;
               end else begin
                  // Illegal op: answer directly, engine is never offered it.
                  state_d             = ST_RESP;
                  rsp_status_d        = ST_OK_ILLEGAL;
                  rsp_valid_d[win_id] = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (eng_ready) begin
               if (eng_done) begin
                  state_d                 = ST_RESP;
                  rsp_status_d            = eng_status;
                  rsp_valid_d[grant_id_q] = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  wd_d    = '0;
               end
            end
         end
         ST_WAIT: begin
            wd_d = wd_q + WD_W'(1);
            if (eng_done) begin
               // {empty, full} maps one-to-one onto the response code.
               state_d                 = ST_RESP;
               rsp_status_d            = eng_status;
               rsp_valid_d[grant_id_q] = 1'b1;
            end else if ((TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1))) begin
               state_d                 = ST_RESP;
               rsp_status_d            = ST_OK_ILLEGAL;
               rsp_valid_d[grant_id_q] = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grant_id_q   <= '0;
         op_q         <= '0;
         data_q       <= '0;
         wd_q         <= '0;
         rsp_valid_q  <= '0;
         rsp_status_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         op_q         <= op_d;
         data_q       <= data_d;
         wd_q         <= wd_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
      end
   end

`ifndef LL_STRICT_PRIO_EN
   // Rotation pointer; starting at NUM_REQ-1 gives requester 0 first turn.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= ID_W'(NUM_REQ - 1);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign eng_valid  = (state_q == ST_ISSUE);
   assign eng_op     = op_q;
   assign eng_data   = data_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_status = rsp_status_q;
   assign busy       = (state_q != ST_IDLE);
   assign grant_id   = grant_id_q;

endmodule
